// File: rtl/ram_stream_master.sv
// ram_stream_master: moves a block of words between a valid/ready stream and
// the core-local RAM port, in either direction, one transfer per start pulse.
module ram_stream_master #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  ramWrEn,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [WIDTH-1:0]      ramWrData,
    input  logic [WIDTH-1:0]      ramRdData,
    input  logic [WIDTH-1:0]      sIn_data,
    input  logic                  sIn_valid,
    output logic                  sIn_ready,
    output logic [WIDTH-1:0]      sOut_data,
    output logic                  sOut_valid,
    input  logic                  sOut_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic                  busy_q;
    logic                  done_q;
    logic [CW-1:0]         len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         issued_q;
    logic [CW-1:0]         completed_q;
    logic                  inflight_q;

    logic [WIDTH-1:0]      fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_cnt;

    logic                  in_write;
    logic                  in_read;
    logic                  more;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_issue;
    logic                  last_pop;

    // Handshake, read-credit and address-wrap decisions for this cycle
    always_comb begin
        in_write   = (state == WRITE);
        in_read    = (state == READ);
        more       = (issued_q < len_q);
        wr_fire    = in_write && more && sIn_valid;
        pop        = (fifo_cnt != 2'd0) && sOut_ready;
        push       = inflight_q;
        occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight_q};
        rd_issue   = in_read && more && (occupancy < (3'd2 + {2'b00, pop}));
        addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
        last_issue = (issued_q == len_q - CW'(1));
        last_pop   = (completed_q == len_q - CW'(1));
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sIn_ready  = in_write && more;
    assign ramWrEn    = wr_fire;
    assign ramWrData  = wr_fire ? sIn_data : '0;
    assign ramAddr    = (wr_fire || rd_issue) ? addr_q : '0;
    assign sOut_valid = (fifo_cnt != 2'd0);
    assign sOut_data  = fifo_mem[rd_ptr];

    // Transfer FSM with registered busy/done and latched length
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            len_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        len_q  <= len;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (mode) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire && last_issue) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                READ: begin
                    if (pop && last_pop) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Address and issue/complete counters, reloaded on an accepted start
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr_q      <= '0;
            issued_q    <= '0;
            completed_q <= '0;
        end else if (state == IDLE && start) begin
            addr_q      <= baseAddr;
            issued_q    <= '0;
            completed_q <= '0;
        end else begin
            if (wr_fire || rd_issue) begin
                addr_q   <= addr_next;
                issued_q <= issued_q + CW'(1);
            end
            if (pop) begin
                completed_q <= completed_q + CW'(1);
            end
        end
    end

    // One read is outstanding in the RAM for exactly one cycle after issue
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
        end
    end

    // Two-entry FIFO catching RAM read data; credit rule keeps it from overflow
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ramRdData;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
